inst_fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the instruction cache.
- Drives the cache's two lookup ports (x = pc, y = pc+4) and consumes the hit/instruction responses.
- Buffers fetched {pc, inst} pairs in an in-order queue for the decoder.
- Handles branch redirects by flushing the queue and any in-flight lookup.

---
 rtl/inst_fetch_queue.sv | 116 +++++++++++
 tb/tb_inst_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: issues paired x/y lookups to the instruction cache
// and buffers returned {pc, inst} pairs in an in-order queue for the decoder.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          FQ_WIDTH = 3,
  parameter int          FQ_DEPTH = 2**FQ_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  output logic                en_rx,
  output logic [31:0]         pcx,
  input  logic                hitx,
  input  logic [31:0]         instx,
  output logic                en_ry,
  output logic [31:0]         pcy,
  input  logic                hity,
  input  logic [31:0]         insty,
  input  logic                br_en,
  input  logic [31:0]         br_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_inst,
  output logic [FQ_WIDTH:0]   fq_count
);

  localparam logic [0:0] ST_ISSUE = 1'b0;
  localparam logic [0:0] ST_WAIT  = 1'b1;

  localparam logic [FQ_WIDTH:0] DEPTH_C = FQ_DEPTH[FQ_WIDTH:0];
  localparam logic [FQ_WIDTH:0] TWO_C   = (FQ_WIDTH+1)'(2);

  logic [0:0]          state;
  logic [31:0]         pc;
  logic [FQ_WIDTH-1:0] head;
  logic [FQ_WIDTH-1:0] tail;
  logic [FQ_WIDTH:0]   count;

  logic [31:0] q_pc   [FQ_DEPTH];
  logic [31:0] q_inst [FQ_DEPTH];

  logic [FQ_WIDTH:0] free_slots;
  logic              lookup;
  logic              push_x;
  logic              push_y;
  logic              pop;
  logic [FQ_WIDTH:0] n_push;

  // A paired lookup needs room for both answers, so issue only with two free slots.
  assign free_slots = DEPTH_C - count;
  assign lookup     = rst && (state == ST_ISSUE) && (free_slots >= TWO_C);

  assign en_rx = lookup;
  assign en_ry = lookup;
  assign pcx   = pc;
  assign pcy   = pc + 32'd4;

  // A y hit is only usable when x also hit; otherwise the pair is re-fetched.
  assign push_x = (state == ST_WAIT) && hitx;
  assign push_y = push_x && hity;
  assign n_push = (FQ_WIDTH+1)'(push_x) + (FQ_WIDTH+1)'(push_y);

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_pc    = out_valid ? q_pc[head]   : 32'h0;
  assign out_inst  = out_valid ? q_inst[head] : 32'h0;
  assign fq_count  = count;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_ISSUE;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (br_en) begin
        state <= ST_ISSUE;
        pc    <= br_target & ~32'h3;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (state == ST_ISSUE) begin
          if (lookup) state <= ST_WAIT;
        end else begin
          state <= ST_ISSUE;
          if (push_y)      pc <= pc + 32'd8;
          else if (push_x) pc <= pc + 32'd4;
        end
        head  <= head + FQ_WIDTH'(pop);
        tail  <= tail + n_push[FQ_WIDTH-1:0];
        count <= count + n_push - (FQ_WIDTH+1)'(pop);
      end
    end
  end

  // NOTE: queue storage has no reset; out_valid masks stale entries, so clearing
  // the array would only cost flops.
  always_ff @(posedge clk) begin
    if (rdy && !br_en) begin
      if (push_x) begin
        q_pc[tail]   <= pc;
        q_inst[tail] <= instx;
      end
      if (push_y) begin
        q_pc[tail + FQ_WIDTH'(1)]   <= pc + 32'd4;
        q_inst[tail + FQ_WIDTH'(1)] <= insty;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table, corner-case
// sequences, and randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int FQ_WIDTH = 3;
  localparam int FQ_DEPTH = 8;
  localparam logic [31:0] I1 = 32'h00000013;
  localparam logic [31:0] I2 = 32'h00100093;

  logic              clk;
  logic              rst;
  logic              rdy;
  logic              en_rx, en_ry;
  logic [31:0]       pcx, pcy;
  logic              hitx, hity;
  logic [31:0]       instx, insty;
  logic              br_en;
  logic [31:0]       br_target;
  logic              out_valid, out_ready;
  logic [31:0]       out_pc, out_inst;
  logic [FQ_WIDTH:0] fq_count;

  inst_fetch_queue #(.RESET_PC(32'h0), .FQ_WIDTH(FQ_WIDTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .en_rx(en_rx), .pcx(pcx), .hitx(hitx), .instx(instx),
    .en_ry(en_ry), .pcy(pcy), .hity(hity), .insty(insty),
    .br_en(br_en), .br_target(br_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .fq_count(fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch pc, a flag for an outstanding lookup, and a plain FIFO.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_wait;

  function automatic bit m_issue();
    return !m_wait && ((FQ_DEPTH - mq.size()) >= 2);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_wait = 1'b0;
  endtask

  task automatic model_update();
    int sz;
    if (rdy) begin
      if (br_en) begin
        mq.delete();
        m_pc   = br_target & ~32'h3;
        m_wait = 1'b0;
      end else begin
        sz = mq.size();
        if (sz != 0 && out_ready) void'(mq.pop_front());
        if (m_wait) begin
          if (hitx) begin
            mq.push_back('{pc: m_pc, inst: instx});
            if (hity) mq.push_back('{pc: m_pc + 32'd4, inst: insty});
            m_pc = m_pc + (hity ? 32'd8 : 32'd4);
          end
          m_wait = 1'b0;
        end else if ((FQ_DEPTH - sz) >= 2) begin
          m_wait = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] e_pc, e_inst;
    e_pc   = (mq.size() != 0) ? mq[0].pc   : 32'h0;
    e_inst = (mq.size() != 0) ? mq[0].inst : 32'h0;
    check("m_en_rx",     en_rx,     m_issue());
    check("m_en_ry",     en_ry,     m_issue());
    check("m_pcx",       pcx,       m_pc);
    check("m_pcy",       pcy,       m_pc + 32'd4);
    check("m_out_valid", out_valid, mq.size() != 0);
    check("m_fq_count",  fq_count,  mq.size());
    check("m_out_pc",    out_pc,    e_pc);
    check("m_out_inst",  out_inst,  e_inst);
  endtask

  // Called at a negedge: drive inputs, then compare settled outputs to the model.
  task automatic apply(input logic r, input logic hx, input logic hy,
                       input logic [31:0] ix, input logic [31:0] iy,
                       input logic b, input logic [31:0] bt, input logic ordy);
    rdy = r; hitx = hx; hity = hy; instx = ix; insty = iy;
    br_en = b; br_target = bt; out_ready = ordy;
    #1;
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cyc(input logic r, input logic hx, input logic hy,
                     input logic [31:0] ix, input logic [31:0] iy,
                     input logic b, input logic [31:0] bt, input logic ordy);
    apply(r, hx, hy, ix, iy, b, bt, ordy);
    advance();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pcx",       pcx,       32'h0);
    check("rst_pcy",       pcy,       32'h4);
    check("rst_en_rx",     en_rx,     1'b0);
    check("rst_fq_count",  fq_count,  '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
          $urandom, $urandom, $urandom_range(0, 39) == 0, $urandom,
          $urandom_range(0, 2) != 0);
    end
  endtask

  typedef struct {
    logic        hx, hy, ordy;
    logic        e_en;
    logic [31:0] e_pcx;
    logic [3:0]  e_cnt;
    logic [31:0] e_out_pc;
    logic [31:0] e_out_inst;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Always-hit cache from reset: fill to 8 with out_ready low, then drain.
    tbl[0]  = '{1, 1, 0, 1, 32'h00, 0, 32'h00, 32'h0};
    tbl[1]  = '{1, 1, 0, 0, 32'h00, 0, 32'h00, 32'h0};
    tbl[2]  = '{1, 1, 0, 1, 32'h08, 2, 32'h00, I1};
    tbl[3]  = '{1, 1, 0, 0, 32'h08, 2, 32'h00, I1};
    tbl[4]  = '{1, 1, 0, 1, 32'h10, 4, 32'h00, I1};
    tbl[5]  = '{1, 1, 0, 0, 32'h10, 4, 32'h00, I1};
    tbl[6]  = '{1, 1, 0, 1, 32'h18, 6, 32'h00, I1};
    tbl[7]  = '{1, 1, 0, 0, 32'h18, 6, 32'h00, I1};
    tbl[8]  = '{1, 1, 0, 0, 32'h20, 8, 32'h00, I1};
    tbl[9]  = '{1, 1, 1, 0, 32'h20, 8, 32'h00, I1};
    tbl[10] = '{1, 1, 1, 0, 32'h20, 7, 32'h04, I2};
    tbl[11] = '{1, 1, 1, 1, 32'h20, 6, 32'h08, I1};
    tbl[12] = '{1, 1, 1, 0, 32'h20, 5, 32'h0C, I2};
    tbl[13] = '{1, 1, 0, 1, 32'h28, 6, 32'h10, I1};

    rst = 1'b0; rdy = 1'b1; hitx = 1'b0; hity = 1'b0; instx = '0; insty = '0;
    br_en = 1'b0; br_target = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_en_rx",     en_rx,     1'b0);
    check("reset_en_ry",     en_ry,     1'b0);
    check("reset_pcx",       pcx,       32'h0);
    check("reset_pcy",       pcy,       32'h4);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_pc",    out_pc,    32'h0);
    check("reset_out_inst",  out_inst,  32'h0);
    check("reset_fq_count",  fq_count,  '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(1'b1, tbl[i].hx, tbl[i].hy, I1, I2, 1'b0, 32'h0, tbl[i].ordy);
      check($sformatf("tbl%0d_en_rx", i),    en_rx,    tbl[i].e_en);
      check($sformatf("tbl%0d_pcx", i),      pcx,      tbl[i].e_pcx);
      check($sformatf("tbl%0d_fq_count", i), fq_count, tbl[i].e_cnt);
      check($sformatf("tbl%0d_out_pc", i),   out_pc,   tbl[i].e_out_pc);
      check($sformatf("tbl%0d_out_inst", i), out_inst, tbl[i].e_out_inst);
      advance();
    end

    // x hit, y miss at 0x10: one entry, next pair starts at 0x14.
    cyc(1, 0, 0, 0, 0, 1, 32'h10, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 32'hAAAA0001, 32'hBBBB0001, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check("xonly_fq_count", fq_count, 1);
    check("xonly_out_pc",   out_pc,   32'h10);
    check("xonly_pcx",      pcx,      32'h14);
    check("xonly_pcy",      pcy,      32'h18);
    advance();

    // Five misses at 0x20 keep re-issuing 0x20, then a hit enqueues the pair.
    cyc(1, 0, 0, 0, 0, 1, 32'h20, 0);
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("miss%0d_pcx", i),   pcx,   32'h20);
      check($sformatf("miss%0d_en_rx", i), en_rx, 1'b1);
      advance();
      cyc(1, 0, 1, 32'hDEAD0000, 32'hDEAD0004, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h11, 32'h22, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1);
    check("misshit_fq_count", fq_count, 2);
    check("misshit_out_pc",   out_pc,   32'h20);
    check("misshit_out_inst", out_inst, 32'h11);
    advance();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check("misshit_out_pc2",   out_pc,   32'h24);
    check("misshit_out_inst2", out_inst, 32'h22);
    advance();

    // Redirect to 0x103 while waiting on a hit with 4 entries queued.
    cyc(1, 0, 0, 0, 0, 1, 32'h0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, I1, I2, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, I1, I2, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 1, I1, I2, 1, 32'h103, 1);
    check("br_pre_fq_count", fq_count, 4);
    check("br_pre_en_rx",    en_rx,    1'b0);
    advance();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check("br_fq_count",  fq_count,  0);
    check("br_out_valid", out_valid, 1'b0);
    check("br_pcx",       pcx,       32'h100);
    check("br_en_rx",     en_rx,     1'b1);
    advance();

    // rdy low for 3 cycles in WAIT: responses ignored, nothing moves.
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, I1, I2, 0, 0, 1);
      check($sformatf("hold%0d_en_rx", i),    en_rx,    1'b0);
      check($sformatf("hold%0d_pcx", i),      pcx,      32'h100);
      check($sformatf("hold%0d_fq_count", i), fq_count, 0);
      advance();
    end
    cyc(1, 1, 1, I1, I2, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check("hold_after_fq_count", fq_count, 2);
    check("hold_after_pcx",      pcx,      32'h108);
    check("hold_after_out_pc",   out_pc,   32'h100);
    advance();

    // 32-bit pc wrap.
    cyc(1, 0, 0, 0, 0, 1, 32'hFFFFFFF8, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, I1, I2, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1);
    check("wrap_pcx",      pcx,      32'h0);
    check("wrap_pcy",      pcy,      32'h4);
    check("wrap_fq_count", fq_count, 2);
    check("wrap_out_pc",   out_pc,   32'hFFFFFFF8);
    advance();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_out_pc2", out_pc, 32'hFFFFFFFC);
    advance();

    random_run(3000);
    async_reset();
    random_run(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
